// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch front end: owns the fetch PC, issues in-order memory
// requests under a credit limit, buffers returned words with their PC in a
// small FIFO for decode, and flushes/drops in-flight work on a redirect.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start; redirects only reload the PCs
// RUN   | fetching; left only by reset
module inst_prefetch_unit #(
    parameter int                 XLEN     = 32,
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter int                 PC_STEP  = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_redirect,
    input  logic [ADDR_W-1:0]          i_redirect_pc,
    output logic                       o_req_valid,
    output logic [ADDR_W-1:0]          o_req_addr,
    input  logic                       i_req_ready,
    input  logic                       i_rsp_valid,
    input  logic [XLEN-1:0]            i_rsp_data,
    output logic                       o_inst_valid,
    output logic [XLEN-1:0]            o_inst_data,
    output logic [ADDR_W-1:0]          o_inst_pc,
    input  logic                       i_inst_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_rsp_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   slot_data_q [DEPTH];
    logic [XLEN-1:0]   slot_data_d [DEPTH];
    logic [ADDR_W-1:0] slot_pc_q   [DEPTH];
    logic [ADDR_W-1:0] slot_pc_d   [DEPTH];

    logic              rsp_ok;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [CW:0]       credit_used;

    // Queued words plus requests in flight must never exceed the queue size,
    // so every response (even ones later dropped) has a slot reserved.
    assign credit_used  = (CW+1)'(count_q) + (CW+1)'(outst_q);
    assign o_req_valid  = (state_q == S_RUN) && !i_redirect && (credit_used < (CW+1)'(DEPTH));
    assign o_req_addr   = fetch_pc_q;
    assign req_fire     = o_req_valid && i_req_ready;

    assign rsp_ok       = i_rsp_valid && (outst_q != '0);
    assign push         = rsp_ok && (drop_q == '0) && !i_redirect;

    assign o_inst_valid = (count_q != '0);
    assign o_inst_data  = o_inst_valid ? slot_data_q[rd_ptr_q] : '0;
    assign o_inst_pc    = o_inst_valid ? slot_pc_q[rd_ptr_q]   : '0;
    assign pop          = o_inst_valid && i_inst_ready && !i_redirect;
    assign o_count      = count_q;
    assign o_rsp_err    = rsp_err_q;

    // Next-state for FSM, PCs, queue pointers and in-flight bookkeeping.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        rsp_err_d   = rsp_err_q;
        slot_data_d = slot_data_q;
        slot_pc_d   = slot_pc_q;

        if (state_q == S_IDLE && i_start) begin
            state_d = S_RUN;
        end

        if (i_rsp_valid && !rsp_ok) begin
            rsp_err_d = 1'b1;
        end

        if (i_redirect) begin
            // Everything still in flight after this cycle belongs to the old
            // stream; a response landing this cycle is already discarded.
            fetch_pc_d = i_redirect_pc;
            resp_pc_d  = i_redirect_pc;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            outst_d    = outst_q - CW'(rsp_ok);
            drop_d     = outst_q - CW'(rsp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_ok);
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                slot_data_d[wr_ptr_q] = i_rsp_data;
                slot_pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                resp_pc_d             = resp_pc_q + STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Queue storage; contents are masked at the outputs while empty, so no reset.
    always_ff @(posedge i_clk) begin
        slot_data_q <= slot_data_d;
        slot_pc_q   <= slot_pc_d;
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Scoreboard bench for inst_prefetch_unit: directed sequences push expected
// (pc, data) pairs, independent monitors compare every delivered word.
module tb_inst_prefetch_unit;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic        redir      = 1'b0;
    logic [31:0] redir_pc   = '0;
    logic        inst_ready = 1'b0;
    logic        mem_v      = 1'b0;
    logic [31:0] mem_d      = '0;
    logic        spur_v     = 1'b0;
    logic [31:0] spur_d     = '0;
    logic        m_fire     = 1'b0;
    int          budget     = 0;
    int          fire_cnt   = 0;
    int unsigned lat        = 1;
    int unsigned cyc        = 0;

    logic        start_w    = 1'b0;
    int          budget_w   = 0;
    logic        mem_w_v    = 1'b0;
    logic [31:0] mem_w_d    = '0;
    logic        w_fire     = 1'b0;
    logic [31:0] w_addr_s   = '0;

    int          checks     = 0;
    int          errors     = 0;
    int unsigned first_pop  = 0;
    int unsigned last_pop   = 0;
    int          pop_cnt    = 0;
    int unsigned start_cyc  = 0;
    int          fire_base  = 0;

    mreq_t mq[$];
    exp_t  exp_q[$];
    exp_t  exp_w[$];

    logic        req_valid, req_ready, rsp_valid;
    logic [31:0] req_addr, rsp_data, inst_data, inst_pc;
    logic        inst_valid, rsp_err;
    logic [2:0]  count;

    logic        w_req_valid, w_inst_valid, w_rsp_err;
    logic [31:0] w_req_addr, w_inst_data, w_inst_pc;
    logic [2:0]  w_count;

    assign req_ready = (budget != 0);
    assign rsp_valid = mem_v | spur_v;
    assign rsp_data  = spur_v ? spur_d : mem_d;

    inst_prefetch_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_redirect(redir), .i_redirect_pc(redir_pc),
        .o_req_valid(req_valid), .o_req_addr(req_addr), .i_req_ready(req_ready),
        .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
        .o_inst_valid(inst_valid), .o_inst_data(inst_data), .o_inst_pc(inst_pc),
        .i_inst_ready(inst_ready), .o_count(count), .o_rsp_err(rsp_err)
    );

    inst_prefetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w),
        .i_redirect(1'b0), .i_redirect_pc(32'h0),
        .o_req_valid(w_req_valid), .o_req_addr(w_req_addr), .i_req_ready(budget_w != 0),
        .i_rsp_valid(mem_w_v), .i_rsp_data(mem_w_d),
        .o_inst_valid(w_inst_valid), .o_inst_data(w_inst_data), .o_inst_pc(w_inst_pc),
        .i_inst_ready(1'b1), .o_count(w_count), .o_rsp_err(w_rsp_err)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc, f(pc)});
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || exp_w.size() != 0 || mq.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_done", 32'(exp_q.size() + exp_w.size() + mq.size()), 32'h0);
    endtask

    // Memory model for the main DUT: in-order responses after 'lat' cycles.
    initial forever begin
        @(posedge clk);
        m_fire = rst_n && req_valid && req_ready;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (mem_v) void'(mq.pop_front());
            if (m_fire) mq.push_back('{cyc + lat, req_addr});
        end
        cyc++;
        #1;
        if (m_fire) begin
            budget--;
            fire_cnt++;
        end
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            mem_v = 1'b1;
            mem_d = f(mq[0].addr);
        end else begin
            mem_v = 1'b0;
            mem_d = '0;
        end
    end

    // Memory model for the wrap-around DUT: fixed 1-cycle latency.
    initial forever begin
        @(posedge clk);
        w_fire   = rst_n && w_req_valid && (budget_w != 0);
        w_addr_s = w_req_addr;
        #1;
        if (w_fire) budget_w--;
        mem_w_v = w_fire;
        mem_w_d = w_fire ? f(w_addr_s) : '0;
    end

    // Scoreboard monitor, main DUT.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready && !redir) begin
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h data %h, expected no delivery", inst_pc, inst_data);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_data", inst_data, e.data);
            end
        end
    end

    // Scoreboard monitor, wrap-around DUT.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n === 1'b1 && w_inst_valid === 1'b1) begin
            if (exp_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_w_inst: got pc %h, expected no delivery", w_inst_pc);
            end else begin
                e = exp_w.pop_front();
                chk("w_inst_pc", w_inst_pc, e.pc);
                chk("w_inst_data", w_inst_data, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) step();
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_w_req_addr", w_req_addr, 32'hFFFF_FFFF);

        // Streaming, 1-cycle memory, decode always ready
        step();
        rst_n = 1'b1;
        inst_ready = 1'b1;
        lat = 1;
        for (int i = 0; i < 8; i++) push_exp(32'(i));
        step();
        start = 1'b1;
        budget = 8;
        start_cyc = cyc;
        pop_cnt = 0;
        step();
        start = 1'b0;
        wait_drain(100);
        chk("stream_pops", 32'(pop_cnt), 32'd8);
        chk("stream_first_latency", first_pop - start_cyc, 32'd3);
        chk("stream_one_per_cycle", last_pop - first_pop, 32'd7);

        // Stall: credit limit caps requests at DEPTH
        step();
        inst_ready = 1'b0;
        fire_base = fire_cnt;
        budget = 100;
        repeat (8) step();
        @(negedge clk);
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_req_valid", 32'(req_valid), 32'h0);
        chk("stall_fires", 32'(fire_cnt - fire_base), 32'd4);
        chk("stall_head_pc", inst_pc, 32'd8);
        chk("stall_head_data", inst_data, f(32'd8));
        for (int i = 8; i < 13; i++) push_exp(32'(i));
        step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("stall_refill_fires", 32'(fire_cnt - fire_base), 32'd5);
        chk("stall_refill_count", 32'(count), 32'd4);
        step();
        budget = 0;
        inst_ready = 1'b1;
        wait_drain(100);
        chk("stall_drained_count", 32'(count), 32'h0);

        // Redirect with two requests in flight at latency 3
        step();
        lat = 3;
        step();
        budget = 2;
        step();
        step();
        redir = 1'b1;
        redir_pc = 32'h40;
        @(negedge clk);
        chk("redir_no_req", 32'(req_valid), 32'h0);
        step();
        redir = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(32'h40 + 32'(i));
        budget = 4;
        @(negedge clk);
        chk("redir_flush_valid", 32'(inst_valid), 32'h0);
        chk("redir_flush_count", 32'(count), 32'h0);
        wait_drain(100);

        // Redirect coincident with a response and a pop
        step();
        budget = 3;
        repeat (4) step();
        redir = 1'b1;
        redir_pc = 32'h80;
        @(negedge clk);
        chk("coinc_head_present", 32'(inst_valid), 32'h1);
        chk("coinc_rsp_present", 32'(rsp_valid), 32'h1);
        chk("coinc_no_req", 32'(req_valid), 32'h0);
        step();
        redir = 1'b0;
        push_exp(32'h80);
        push_exp(32'h81);
        budget = 2;
        @(negedge clk);
        chk("coinc_flush_valid", 32'(inst_valid), 32'h0);
        wait_drain(100);

        // PC wrap from RESET_PC = all ones
        step();
        exp_w.push_back('{32'hFFFF_FFFF, f(32'hFFFF_FFFF)});
        exp_w.push_back('{32'h0000_0000, f(32'h0000_0000)});
        exp_w.push_back('{32'h0000_0001, f(32'h0000_0001)});
        start_w = 1'b1;
        budget_w = 3;
        step();
        start_w = 1'b0;
        wait_drain(100);
        chk("w_rsp_err", 32'(w_rsp_err), 32'h0);
        chk("w_count", 32'(w_count), 32'h0);

        // Reset mid-operation, then spurious response in IDLE
        step();
        rst_n = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rst2_req_valid", 32'(req_valid), 32'h0);
        chk("rst2_count", 32'(count), 32'h0);
        chk("rst2_req_addr", req_addr, 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_clear", 32'(rsp_err), 32'h0);
        step();
        spur_v = 1'b1;
        spur_d = 32'hDEAD_BEEF;
        step();
        spur_v = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(rsp_err), 32'h1);
        chk("err_count", 32'(count), 32'h0);
        chk("err_inst_valid", 32'(inst_valid), 32'h0);
        step();
        redir = 1'b1;
        redir_pc = 32'h200;
        step();
        redir = 1'b0;
        @(negedge clk);
        chk("idle_redir_addr", req_addr, 32'h200);
        chk("idle_redir_no_req", 32'(req_valid), 32'h0);
        step();
        start = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h300;
        push_exp(32'h300);
        push_exp(32'h301);
        step();
        start = 1'b0;
        redir = 1'b0;
        budget = 2;
        wait_drain(100);
        chk("err_sticky", 32'(rsp_err), 32'h1);
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("err_reset", 32'(rsp_err), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
